// File: rtl/rtl_handshake_source.sv
// Ready/valid result source: reduces operand pairs, queues them in a small FIFO,
// presents them downstream and flags downstream stalls beyond a programmable limit.
module rtl_handshake_source #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 2,
    parameter int STALL_LIMIT = 15
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [WIDTH-1:0]           in1,
    input  logic [WIDTH-1:0]           in2,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       handshake_valid,
    input  logic                       handshake_ready,
    output logic                       out,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       stall_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t             state_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [OCC_W-1:0]   occ_r;
    logic               mem_out_r  [DEPTH];
    logic [WIDTH-1:0]   mem_data_r [DEPTH];
    logic               head_out_r;
    logic [WIDTH-1:0]   head_data_r;
    logic               in_ready_r;
    logic               valid_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic               stall_err_r;

    logic               push_s;
    logic               pop_s;
    logic               push_out_s;
    logic [WIDTH-1:0]   push_data_s;
    logic [OCC_W-1:0]   occ_next_s;
    logic [PTR_W-1:0]   wr_ptr_next_s;
    logic [PTR_W-1:0]   rd_ptr_next_s;
    logic               head_out_next_s;
    logic [WIDTH-1:0]   head_data_next_s;

    // Handshakes, entry transform and next FIFO bookkeeping.
    always_comb begin
        push_s        = in_valid && in_ready_r;
        pop_s         = valid_r && handshake_ready;
        push_out_s    = (|in1) & (&in1);
        push_data_s   = in1 ^ in2;
        wr_ptr_next_s = push_s ? (wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1}) : wr_ptr_r;
        rd_ptr_next_s = pop_s  ? (rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1}) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   occ_next_s = occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
            2'b01:   occ_next_s = occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
            default: occ_next_s = occ_r;
        endcase
    end

    // Next head entry; a push landing on the new head slot bypasses the memory.
    always_comb begin
        head_out_next_s  = 1'b0;
        head_data_next_s = {WIDTH{1'b0}};
        if (occ_next_s == {OCC_W{1'b0}}) begin
            head_out_next_s  = 1'b0;
            head_data_next_s = {WIDTH{1'b0}};
        end else if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_out_next_s  = push_out_s;
            head_data_next_s = push_data_s;
        end else begin
            head_out_next_s  = mem_out_r[rd_ptr_next_s];
            head_data_next_s = mem_data_r[rd_ptr_next_s];
        end
    end

    // FIFO storage, pointers, occupancy and registered head outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            occ_r       <= {OCC_W{1'b0}};
            head_out_r  <= 1'b0;
            head_data_r <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_out_r[i]  <= 1'b0;
                mem_data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_out_r[wr_ptr_r]  <= push_out_s;
                mem_data_r[wr_ptr_r] <= push_data_s;
            end
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            occ_r       <= occ_next_s;
            head_out_r  <= head_out_next_s;
            head_data_r <= head_data_next_s;
        end
    end

    // Upstream fill-level FSM with its registered ready/valid outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b1;
            valid_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) state_r <= ST_PARTIAL;
                    else        state_r <= ST_EMPTY;
                end
                ST_PARTIAL: begin
                    if (push_s && !pop_s && (occ_next_s == OCC_W'(DEPTH)))
                        state_r <= ST_FULL;
                    else if (pop_s && !push_s && (occ_next_s == {OCC_W{1'b0}}))
                        state_r <= ST_EMPTY;
                    else
                        state_r <= ST_PARTIAL;
                end
                ST_FULL: begin
                    if (pop_s) state_r <= ST_PARTIAL;
                    else       state_r <= ST_FULL;
                end
                default: state_r <= ST_EMPTY;
            endcase
            in_ready_r <= (occ_next_s != OCC_W'(DEPTH));
            valid_r    <= (occ_next_s != {OCC_W{1'b0}});
        end
    end

    // Consecutive-stall counter and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            stall_err_r <= 1'b0;
        end else begin
            if (!valid_r || pop_s)
                stall_cnt_r <= {CNT_W{1'b0}};
            else if (stall_cnt_r != CNT_W'(STALL_LIMIT))
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            else
                stall_cnt_r <= stall_cnt_r;
            if (stall_cnt_r == CNT_W'(STALL_LIMIT))
                stall_err_r <= 1'b1;
            else
                stall_err_r <= stall_err_r;
        end
    end

    assign in_ready        = in_ready_r;
    assign handshake_valid = valid_r;
    assign out             = head_out_r;
    assign out_data        = head_data_r;
    assign occupancy       = occ_r;
    assign stall_err       = stall_err_r;

endmodule

// File: doc/rtl_handshake_source.md
# rtl_handshake_source

Transmitter for the `handshake_ready`/`handshake_valid` channel that the RTL monitor observes. It accepts operand pairs (`in1`, `in2`) from upstream and computes the reduction result `out` plus a payload word. It queues accepted results in a small FIFO and presents them downstream under a ready/valid protocol whose invariants the monitor asserts. It also detects downstream stalls that exceed a programmable limit.

## Interface
- `WIDTH`, default 4: operand width (≥2).
- `DEPTH`, default 2: result FIFO entries (power of two, ≥2).
- `STALL_LIMIT`, default 15: consecutive stalled cycles that raise `stall_err` (≥1).

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `in1`  in  WIDTH  operand A, sampled on accept.
- `in2`  in  WIDTH  operand B, sampled on accept.
- `in_valid`  in  1  upstream offers an operand pair.
- `in_ready`  out  1  block can accept this cycle.
- `handshake_valid`  out  1  result presented downstream.
- `handshake_ready`  in  1  downstream accepts the result.
- `out`  out  1  result bit of the head entry.
- `out_data`  out  WIDTH  payload of the head entry.
- `occupancy`  out  clog2(DEPTH)+1  number of entries held.
- `stall_err`  out  1  sticky flag for a stall over the limit.

## Operation
- Accept: `in_valid && in_ready`. The pair is transformed and pushed at the tail.
  - `orr = |in1`, `andr = &in1`.
  - `out = orr & andr` (1 only when `in1` is all ones).
  - `out_data = in1 ^ in2`, WIDTH bits, no carry.
- Deliver: `handshake_valid && handshake_ready` pops the head.
- `in_ready = (occupancy != DEPTH)`. It depends only on registered state, with no combinational path from `handshake_ready`.
- `handshake_valid = (occupancy != 0)`. `out` and `out_data` come from the head entry.
- Hold rule: once `handshake_valid` rises, `handshake_valid`, `out` and `out_data` stay stable until the cycle `handshake_ready` is sampled high.
- When the FIFO is empty, `out` and `out_data` are 0.
- Simultaneous push and pop:
  - Non-empty and non-full: occupancy is unchanged and both pointers advance.
  - Full: no push occurs (`in_ready` is low), the pop proceeds, and `occupancy` becomes DEPTH-1.
  - Empty: no pop occurs (`handshake_valid` is low), the push proceeds, and `occupancy` becomes 1.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. `occupancy` is tracked separately and saturates in range by construction.
- Stall counter `stall_cnt`, clog2(STALL_LIMIT+1) bits:
  - Increments when `handshake_valid && !handshake_ready`, saturating at STALL_LIMIT.
  - Clears to 0 on any delivery or whenever `handshake_valid` is low.
- `stall_err` is set in the cycle after `stall_cnt` reaches STALL_LIMIT. It is cleared only by `RESET`.
- Upstream state machine, derived from `occupancy`:
  - States: EMPTY, PARTIAL, FULL.
  - EMPTY to PARTIAL on push. PARTIAL to FULL on push without pop. FULL to PARTIAL on pop. PARTIAL to EMPTY on pop without push.
  - With DEPTH=2, PARTIAL means exactly one entry.

## Timing
- `RESET` sampled high clears the FIFO, pointers, `stall_cnt` and `stall_err`. This also applies mid-transfer: in-flight entries are discarded and no partial handshake survives.
- Output values during and immediately after reset:
  - `in_ready` = 1.
  - `handshake_valid` = 0.
  - `out` = 0, `out_data` = 0.
  - `occupancy` = 0.
  - `stall_err` = 0.
- Latency: a pair accepted at edge N into an empty FIFO gives `handshake_valid` = 1 after edge N; the earliest delivery is at edge N+1.
- Throughput: one transfer per cycle in steady state when `handshake_ready` is held high.
- A full FIFO that pops at edge N shows `in_ready` = 1 after edge N.
- `stall_err` rises after exactly STALL_LIMIT+1 consecutive stalled edges.

## Test plan
- Reset, then `in1`=4'hF, `in2`=4'h3, pulsing `in_valid` once with `handshake_ready`=1: the next cycle shows `handshake_valid`=1, `out`=1, `out_data`=4'hC; the cycle after shows `handshake_valid`=0 and `occupancy`=0.
- Hold `handshake_ready`=0 and push 4'h1 then 4'h7 (`in2`=0): `occupancy`=2 and `in_ready`=0. A third `in_valid` is ignored. Releasing ready delivers `out`=0, `out_data`=4'h1, then `out`=0, `out_data`=4'h7.
- With the FIFO full, assert `in_valid` and `handshake_ready` together: one pop and no push, so `occupancy` goes 2 → 1. Next cycle, a push and a pop leave `occupancy`=1.
- Hold `handshake_valid` with `handshake_ready`=0 for 16 cycles (STALL_LIMIT=15): `stall_err` rises on the 16th edge and stays 1 after ready returns.
- Assert `RESET` with 2 entries queued and `stall_err`=1: the next cycle shows `occupancy`=0, `handshake_valid`=0, `out_data`=0, `stall_err`=0 and `in_ready`=1.
- Stream 20 random pairs with random `handshake_ready`: each delivered `out` equals `&in1` and `out_data` equals `in1^in2` in order, and the payload never changes while valid is high and ready is low.
